audio_env_pwm: RTL and testbench

Downstream output stage for the sine voice. It latches the 7-bit offset-binary sample once per 1024-clock frame and scales it by a gate-driven attack/sustain/release envelope. The scaled sample drives a 1-bit PWM output at 128 clocks per PWM period, 8 periods per frame. It shares the frame counter `subsample_phase` with the sine generator.

---
 rtl/audio_pkg.sv | 30 +++
 rtl/envelope_fsm.sv | 103 ++++++++++
 rtl/audio_env_pwm.sv | 75 +++++++
 tb/tb_audio_env_pwm.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants, envelope state type and sample scaling helper for the
// sine voice output stage.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    localparam int PHASE_LATCH     = 9;
    localparam int PHASE_SCALE     = 10;
    localparam int MIDSCALE        = 64;
    localparam int LEVEL_MAX       = 127;
    localparam int PWM_PERIOD_BITS = 7;

    // Offset-binary sample times level, floor-divided by 128, recentred at midscale.
    function automatic logic [6:0] scale_duty(input logic [6:0] sample_q,
                                              input logic [6:0] level);
        logic signed [14:0] s;
        logic signed [14:0] lvl;
        logic signed [14:0] p;
        s   = $signed({8'd0, sample_q}) - 15'(MIDSCALE);
        lvl = $signed({8'd0, level});
        p   = s * lvl;
        return 7'((p >>> 7) + 15'(MIDSCALE));
    endfunction

endpackage

// File: rtl/envelope_fsm.sv
// Gate-driven attack/sustain/release envelope, advanced once per frame on
// the update strobe.
module envelope_fsm
    import audio_pkg::*;
#(
    parameter int LEVEL_BITS = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  update,
    input  logic                  gate,
    input  logic [3:0]            attack_step,
    input  logic [3:0]            release_step,
    output logic [LEVEL_BITS-1:0] level,
    output logic                  busy
);

    localparam logic [LEVEL_BITS-1:0] LVL_MAX  = LEVEL_BITS'(LEVEL_MAX);
    localparam logic [LEVEL_BITS-1:0] LVL_ZERO = {LEVEL_BITS{1'b0}};

    env_state_t            state_r;
    env_state_t            state_s;
    logic [LEVEL_BITS-1:0] level_r;
    logic [LEVEL_BITS-1:0] level_s;
    logic [LEVEL_BITS-1:0] up_s;
    logic [LEVEL_BITS-1:0] down_s;
    logic [LEVEL_BITS:0]   sum_s;
    logic                  busy_r;

    // Candidate levels for an attack step and a release step from the current level.
    always_comb begin
        sum_s  = {1'b0, level_r} + (LEVEL_BITS+1)'(attack_step);
        up_s   = LVL_MAX;
        down_s = LVL_ZERO;
        if (attack_step == 4'd0) begin
            up_s = LVL_MAX;
        end else if (sum_s > {1'b0, LVL_MAX}) begin
            up_s = LVL_MAX;
        end else begin
            up_s = sum_s[LEVEL_BITS-1:0];
        end
        if (release_step == 4'd0) begin
            down_s = LVL_ZERO;
        end else if (level_r <= LEVEL_BITS'(release_step)) begin
            down_s = LVL_ZERO;
        end else begin
            down_s = level_r - LEVEL_BITS'(release_step);
        end
    end

    // Next state and level; a falling gate always takes the release path,
    // so it overrides any saturation reached on the same edge.
    always_comb begin
        state_s = state_r;
        level_s = level_r;
        if (update) begin
            case (state_r)
                IDLE: begin
                    if (gate) begin
                        level_s = up_s;
                        state_s = (up_s == LVL_MAX) ? SUSTAIN : ATTACK;
                    end else begin
                        level_s = LVL_ZERO;
                        state_s = IDLE;
                    end
                end
                ATTACK, SUSTAIN, RELEASE: begin
                    if (gate) begin
                        level_s = up_s;
                        state_s = (up_s == LVL_MAX) ? SUSTAIN : ATTACK;
                    end else begin
                        level_s = down_s;
                        state_s = (down_s == LVL_ZERO) ? IDLE : RELEASE;
                    end
                end
                default: begin
                    level_s = LVL_ZERO;
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
            level_s = level_r;
        end
    end

    // State, level and busy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            level_r <= LVL_ZERO;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            level_r <= level_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    assign level = level_r;
    assign busy  = busy_r;

endmodule

// File: rtl/audio_env_pwm.sv
// Output stage: latches a sample each frame, scales it by the envelope and
// renders it as a 128-clock PWM bit stream.
module audio_env_pwm
    import audio_pkg::*;
#(
    parameter int PHASE_BITS = 10,
    parameter int LEVEL_BITS = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PHASE_BITS-1:0] subsample_phase,
    input  logic [6:0]            sample,
    input  logic                  gate,
    input  logic [3:0]            attack_step,
    input  logic [3:0]            release_step,
    output logic                  pwm_out,
    output logic [LEVEL_BITS-1:0] env_level,
    output logic                  busy
);

    localparam logic [PHASE_BITS-1:0]      LATCH_PH = PHASE_BITS'(PHASE_LATCH);
    localparam logic [PHASE_BITS-1:0]      SCALE_PH = PHASE_BITS'(PHASE_SCALE);
    localparam logic [PWM_PERIOD_BITS-1:0] PER_END  = {PWM_PERIOD_BITS{1'b1}};
    localparam logic [6:0]                 MID      = 7'(MIDSCALE);

    logic       latch_s;
    logic       scale_s;
    logic       period_end_s;
    logic [6:0] sample_q_r;
    logic [6:0] duty_next_r;
    logic [6:0] duty_active_r;
    logic       pwm_r;

    assign latch_s      = (subsample_phase == LATCH_PH);
    assign scale_s      = (subsample_phase == SCALE_PH);
    assign period_end_s = (subsample_phase[PWM_PERIOD_BITS-1:0] == PER_END);

    envelope_fsm #(
        .LEVEL_BITS (LEVEL_BITS)
    ) u_env (
        .clk          (clk),
        .rst          (rst),
        .update       (latch_s),
        .gate         (gate),
        .attack_step  (attack_step),
        .release_step (release_step),
        .level        (env_level),
        .busy         (busy)
    );

    // Sample latch, scaler and PWM; duty only switches at a period boundary
    // so a period never mixes two duty values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q_r    <= MID;
            duty_next_r   <= MID;
            duty_active_r <= MID;
            pwm_r         <= 1'b0;
        end else begin
            if (latch_s) begin
                sample_q_r <= sample;
            end
            if (scale_s) begin
                duty_next_r <= scale_duty(sample_q_r, 7'(env_level));
            end
            if (period_end_s) begin
                duty_active_r <= duty_next_r;
            end
            pwm_r <= (subsample_phase[PWM_PERIOD_BITS-1:0] < duty_active_r);
        end
    end

    assign pwm_out = pwm_r;

endmodule

// File: tb/tb_audio_env_pwm.sv
// Self-checking bench for audio_env_pwm: directed envelope table, PWM duty
// counts and randomized frames against a behavioural frame-level model.
module tb_audio_env_pwm;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] phase;
    logic [6:0] sample;
    logic       gate;
    logic [3:0] att_step;
    logic [3:0] rel_step;
    logic       pwm_out;
    logic [6:0] env_level;
    logic       busy;

    int checks = 0;
    int passes = 0;

    // Reference model: the envelope is just "a level that is either active or not".
    int m_level, m_sample_q, m_duty_next, m_duty_active, m_pwm;
    bit m_active;

    typedef struct {
        bit g;
        int a;
        int r;
        int lvl;
        bit bsy;
    } env_vec_t;

    env_vec_t vecs[$];

    always #5 clk = ~clk;

    audio_env_pwm #(.PHASE_BITS(10), .LEVEL_BITS(7)) dut (
        .clk             (clk),
        .rst             (rst),
        .subsample_phase (phase),
        .sample          (sample),
        .gate            (gate),
        .attack_step     (att_step),
        .release_step    (rel_step),
        .pwm_out         (pwm_out),
        .env_level       (env_level),
        .busy            (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    endtask

    function automatic int floor_div128(input int p);
        return (p >= 0) ? (p / 128) : -((-p + 127) / 128);
    endfunction

    task automatic model_edge();
        int n_level, n_sq, n_dn, n_da, n_pwm, ph;
        bit n_active;
        ph = int'(phase);
        n_level = m_level; n_active = m_active; n_sq = m_sample_q;
        n_dn = m_duty_next; n_da = m_duty_active;
        if (rst) begin
            n_level = 0; n_active = 0; n_sq = 64; n_dn = 64; n_da = 64; n_pwm = 0;
        end else begin
            if (ph == 9) begin
                if (gate) begin
                    n_level = (att_step == 0) ? 127 : m_level + int'(att_step);
                    if (n_level > 127) n_level = 127;
                    n_active = 1;
                end else if (m_active) begin
                    n_level = (rel_step == 0) ? 0 : m_level - int'(rel_step);
                    if (n_level < 0) n_level = 0;
                    n_active = (n_level != 0);
                end else begin
                    n_level = 0;
                end
                n_sq = int'(sample);
            end
            if (ph == 10) n_dn = floor_div128((m_sample_q - 64) * m_level) + 64;
            if (ph % 128 == 127) n_da = m_duty_next;
            n_pwm = ((ph % 128) < m_duty_active) ? 1 : 0;
        end
        m_level = n_level; m_active = n_active; m_sample_q = n_sq;
        m_duty_next = n_dn; m_duty_active = n_da; m_pwm = n_pwm;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("pwm_out", int'(pwm_out), m_pwm);
        check("env_level", int'(env_level), m_level);
        check("busy", int'(busy), int'(m_active));
        phase = phase + 10'd1;
    endtask

    task automatic run_until_next(input int ph);
        while (int'(phase) != ph) tick();
    endtask

    task automatic count_period(input int start, output int highs);
        run_until_next(start);
        highs = 0;
        for (int i = 0; i < 128; i++) begin
            tick();
            highs += int'(pwm_out);
        end
    endtask

    initial begin
        int h, lv, rst_at, wig;
        int scl_s[3];
        int scl_e[3];

        // Attack at step 8, hold in sustain, release at 15 down to idle.
        for (int k = 1; k <= 15; k++) vecs.push_back('{1'b1, 8, 0, 8 * k, 1'b1});
        vecs.push_back('{1'b1, 8, 0, 127, 1'b1});
        vecs.push_back('{1'b1, 8, 0, 127, 1'b1});
        lv = 127;
        for (int k = 0; k < 8; k++) begin
            lv -= 15;
            vecs.push_back('{1'b0, 0, 15, lv, 1'b1});
        end
        vecs.push_back('{1'b0, 0, 15, 0, 1'b0});
        // Instant attack, release at 8 to level 63, then instant retrigger.
        vecs.push_back('{1'b1, 0, 0, 127, 1'b1});
        for (int k = 1; k <= 8; k++) vecs.push_back('{1'b0, 0, 8, 127 - 8 * k, 1'b1});
        vecs.push_back('{1'b1, 0, 0, 127, 1'b1});

        rst = 1'b1; phase = 10'd500; gate = 1'b0; sample = 7'd100;
        att_step = 4'd0; rel_step = 4'd0;
        tick();
        tick();
        check("reset_env_level", int'(env_level), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_pwm", int'(pwm_out), 0);
        rst = 1'b0;
        count_period(0, h);
        check("reset_duty_highs", h, 64);

        sample = 7'd127;
        foreach (vecs[k]) begin
            gate = vecs[k].g;
            att_step = 4'(vecs[k].a);
            rel_step = 4'(vecs[k].r);
            run_until_next(9);
            tick();
            check($sformatf("table_level[%0d]", k), int'(env_level), vecs[k].lvl);
            check($sformatf("table_busy[%0d]", k), int'(busy), int'(vecs[k].bsy));
        end

        // Duty at full level for extreme and midscale samples.
        scl_s = '{127, 0, 64};
        scl_e = '{126, 0, 64};
        for (int i = 0; i < 3; i++) begin
            sample = 7'(scl_s[i]);
            run_until_next(9);
            tick();
            count_period(128, h);
            check($sformatf("scale_highs[%0d]", scl_s[i]), h, scl_e[i]);
        end

        // New duty must not appear before the second period of the frame.
        sample = 7'd127;
        count_period(0, h);
        check("glitch_first_period", h, 64);
        count_period(128, h);
        check("glitch_second_period", h, 126);

        for (int f = 0; f < 15; f++) begin
            run_until_next(0);
            gate = ($urandom_range(0, 9) < 6);
            att_step = 4'($urandom_range(0, 15));
            rel_step = 4'($urandom_range(0, 15));
            sample = 7'($urandom_range(0, 127));
            rst_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1023)) : -1;
            wig = int'($urandom_range(10, 1023));
            for (int i = 0; i < 1024; i++) begin
                rst = (int'(phase) == rst_at);
                if (int'(phase) == wig) gate = ~gate;
                tick();
            end
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
